// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one registered tag/data broadcast per cycle.
// Define CDB_PERF_CNT_EN to add the saturating conflict_cnt output.
module cdb_arbiter #(
    parameter int              N_REQ       = 4,
    parameter int              TAG_W       = 3,
    parameter int              DATA_W      = 32,
    parameter logic [TAG_W-1:0] INVALID_TAG = '0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      cdb_hold,
    input  logic                      cdb_flush,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]               conflict_cnt
`endif
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] winner;
    logic             found;
    logic             transfer;
    int               idx;

    // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign transfer = found & ~cdb_hold & ~cdb_flush & ~RST;

    always_comb begin
        req_ready = '0;
        if (transfer) req_ready[winner] = 1'b1;
    end

    // Flush wins over hold; hold freezes both the bus register and the pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= INVALID_TAG;
            cdb_data  <= '0;
            rr_ptr    <= '0;
        end else if (cdb_flush) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= INVALID_TAG;
            cdb_data  <= '0;
        end else if (!cdb_hold) begin
            if (found) begin
                cdb_valid <= 1'b1;
                cdb_tag   <= req_tag[int'(winner)*TAG_W +: TAG_W];
                cdb_data  <= req_data[int'(winner)*DATA_W +: DATA_W];
                rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            end else begin
                cdb_valid <= 1'b0;
                cdb_tag   <= INVALID_TAG;
                cdb_data  <= '0;
            end
        end
    end

`ifdef CDB_PERF_CNT_EN
    // Counts granted cycles that had contention; sticks at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            conflict_cnt <= '0;
        end else if (transfer && ($countones(req_valid) >= 2) && (conflict_cnt != 32'hFFFF_FFFF)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model + expected-broadcast queue,
// directed scenarios followed by a randomized phase. Covers conflict_cnt when CDB_PERF_CNT_EN is set.
module tb_cdb_arbiter;

    localparam int N      = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam logic [TAG_W-1:0] INV = '0;

    logic                    CLK;
    logic                    RST;
    logic [N-1:0]            req_valid;
    logic [N*TAG_W-1:0]      req_tag;
    logic [N*DATA_W-1:0]     req_data;
    logic [N-1:0]            req_ready;
    logic                    cdb_hold;
    logic                    cdb_flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
`ifdef CDB_PERF_CNT_EN
    logic [31:0]             conflict_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [TAG_W+DATA_W-1:0] exp_q[$];
    logic [TAG_W-1:0]        tag_log[$];

    logic [TAG_W-1:0]  r_tag[N];
    logic [DATA_W-1:0] r_data[N];
    int                cnt[N];
    logic [N-1:0]      fired;

    logic              m_valid;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    int                m_rr;
    logic              beat_due;
    logic              mon_found;
    int                mon_w;
    int                mon_idx;
    logic [N-1:0]      mon_ready;

    cdb_arbiter #(.N_REQ(N), .TAG_W(TAG_W), .DATA_W(DATA_W), .INVALID_TAG(INV)) dut (
        .CLK(CLK),
        .RST(RST),
        .req_valid(req_valid),
        .req_tag(req_tag),
        .req_data(req_data),
        .req_ready(req_ready),
        .cdb_hold(cdb_hold),
        .cdb_flush(cdb_flush),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data)
`ifdef CDB_PERF_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]                    = (cnt[i] != 0);
            req_tag[i*TAG_W +: TAG_W]       = r_tag[i];
            req_data[i*DATA_W +: DATA_W]    = r_data[i];
        end
    end

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic launch(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d, input int n);
        r_tag[i]  = t;
        r_data[i] = d;
        cnt[i]    = n;
    endtask

    function automatic logic [TAG_W-1:0] log_at(input int k);
        return (k < tag_log.size()) ? tag_log[k] : INV;
    endfunction

    // requester driver: after an accepted beat, either present the next result or drop valid
    always @(posedge CLK) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
                if (cnt[i] > 0) cnt[i] = cnt[i] - 1;
                r_data[i] = $urandom;
            end
        end
    end

    // scoreboard / reference model, sampled mid-cycle
    always @(negedge CLK) begin
        if (RST) begin
            m_valid  = 1'b0;
            m_tag    = INV;
            m_data   = '0;
            m_rr     = 0;
            beat_due = 1'b0;
            exp_q.delete();
            fired    = '0;
        end else begin
            if (beat_due) begin
                {m_tag, m_data} = exp_q.pop_front();
                m_valid  = 1'b1;
                beat_due = 1'b0;
                tag_log.push_back(cdb_tag);
            end
            check_eq("cdb_valid", 64'(cdb_valid), 64'(m_valid));
            check_eq("cdb_tag",   64'(cdb_tag),   64'(m_tag));
            check_eq("cdb_data",  64'(cdb_data),  64'(m_data));
            for (int i = 0; i < N; i++)
                if (req_valid[i] && r_tag[i] == INV)
                    $display("protocol error: requester %0d presents the invalid tag", i);
            mon_found = 1'b0;
            mon_w     = 0;
            for (int k = 0; k < N; k++) begin
                mon_idx = (m_rr + k) % N;
                if (!mon_found && req_valid[mon_idx]) begin
                    mon_found = 1'b1;
                    mon_w     = mon_idx;
                end
            end
            mon_ready = '0;
            if (mon_found && !cdb_hold && !cdb_flush) mon_ready[mon_w] = 1'b1;
            check_eq("req_ready", 64'(req_ready), 64'(mon_ready));
            fired = req_valid & req_ready;
            if (cdb_flush) begin
                m_valid = 1'b0; m_tag = INV; m_data = '0;
            end else if (!cdb_hold) begin
                if (mon_found) begin
                    exp_q.push_back({r_tag[mon_w], r_data[mon_w]});
                    beat_due = 1'b1;
                    m_rr     = (mon_w + 1) % N;
                end else begin
                    m_valid = 1'b0; m_tag = INV; m_data = '0;
                end
            end
        end
    end

    initial begin
        RST = 1'b1; cdb_hold = 1'b0; cdb_flush = 1'b0; fired = '0;
        for (int i = 0; i < N; i++) launch(i, INV, '0, 0);
        repeat (2) @(posedge CLK); #2;
        check_eq("rst_valid", 64'(cdb_valid), 64'd0);
        check_eq("rst_tag",   64'(cdb_tag),   64'(INV));
        check_eq("rst_data",  64'(cdb_data),  64'd0);
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        RST = 1'b0;

        // single request
        @(posedge CLK); #2;
        launch(1, 3'd2, 32'hDEAD_BEEF, 1);
        @(negedge CLK); check_eq("single_ready", 64'(req_ready), 64'b0010);
        @(negedge CLK);
        check_eq("single_valid", 64'(cdb_valid), 64'd1);
        check_eq("single_tag",   64'(cdb_tag),   64'd2);
        check_eq("single_data",  64'(cdb_data),  64'hDEAD_BEEF);
        @(negedge CLK);
        check_eq("single_idle_valid", 64'(cdb_valid), 64'd0);
        check_eq("single_idle_tag",   64'(cdb_tag),   64'(INV));

        // reset in the middle of a broadcast
        @(posedge CLK); #2;
        launch(2, 3'd3, $urandom, 1);
        @(posedge CLK); #2;
        check_eq("pre_reset_tag", 64'(cdb_tag), 64'd3);
        #1; RST = 1'b1; #1;
        check_eq("async_rst_valid", 64'(cdb_valid), 64'd0);
        check_eq("async_rst_tag",   64'(cdb_tag),   64'(INV));
        check_eq("async_rst_data",  64'(cdb_data),  64'd0);
        launch(0, 3'd1, $urandom, 1);
        launch(3, 3'd4, $urandom, 1);
        #1; check_eq("rst_ready_gated", 64'(req_ready), 64'd0);
        @(posedge CLK); #2;
        RST = 1'b0;
        tag_log.delete();
        repeat (4) @(posedge CLK); #2;
        check_eq("first_after_reset", 64'(log_at(0)), 64'd1);
        check_eq("second_after_reset", 64'(log_at(1)), 64'd4);

        // all requesters continuously valid
        tag_log.delete();
        for (int i = 0; i < N; i++) launch(i, TAG_W'(i + 1), $urandom, 2);
        repeat (10) @(posedge CLK); #2;
        for (int k = 0; k < 8; k++) check_eq("rr_order", 64'(log_at(k)), 64'(k % 4 + 1));

        // hold with a pending requester
        launch(1, 3'd5, $urandom, 1);
        @(posedge CLK); #2;
        cdb_hold = 1'b1;
        launch(2, 3'd7, $urandom, 1);
        repeat (3) begin
            @(negedge CLK);
            check_eq("hold_valid", 64'(cdb_valid), 64'd1);
            check_eq("hold_tag",   64'(cdb_tag),   64'd5);
            check_eq("hold_ready", 64'(req_ready), 64'd0);
            @(posedge CLK); #2;
        end
        cdb_hold = 1'b0;
        @(negedge CLK); check_eq("after_hold_ready", 64'(req_ready), 64'b0100);
        @(negedge CLK); check_eq("after_hold_tag",   64'(cdb_tag),   64'd7);

        // flush overriding hold
        @(posedge CLK); #2;
        launch(3, 3'd6, $urandom, 1);
        @(posedge CLK); #2;
        check_eq("pre_flush_tag", 64'(cdb_tag), 64'd6);
        cdb_hold = 1'b1; cdb_flush = 1'b1;
        launch(0, 3'd1, $urandom, 1);
        #1; check_eq("flush_ready", 64'(req_ready), 64'd0);
        @(posedge CLK); #2;
        check_eq("flush_valid", 64'(cdb_valid), 64'd0);
        check_eq("flush_tag",   64'(cdb_tag),   64'(INV));
        cdb_hold = 1'b0; cdb_flush = 1'b0;
        launch(1, 3'd2, $urandom, 1);
        @(negedge CLK); check_eq("post_flush_ready", 64'(req_ready), 64'b0001);
        repeat (4) @(posedge CLK); #2;

        // randomized traffic with hold/flush
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                if (cnt[i] == 0 && $urandom_range(0, 3) == 0)
                    launch(i, TAG_W'($urandom_range(1, 7)), $urandom, $urandom_range(1, 3));
            cdb_hold  = ($urandom_range(0, 4) == 0);
            cdb_flush = ($urandom_range(0, 9) == 0);
            @(posedge CLK); #2;
        end
        cdb_hold = 1'b0; cdb_flush = 1'b0;
        repeat (15) @(posedge CLK); #2;
        check_eq("drained_valid", 64'(req_valid), 64'd0);
        check_eq("exp_q_empty", 64'(exp_q.size() + int'(beat_due)), 64'd0);

`ifdef CDB_PERF_CNT_EN
        RST = 1'b1;
        @(posedge CLK); #2;
        check_eq("conf_reset", 64'(conflict_cnt), 64'd0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) launch(i, TAG_W'(i + 1), $urandom, 100);
        repeat (10) @(posedge CLK); #2;
        cnt[1] = 0; cnt[2] = 0;
        repeat (5) @(posedge CLK); #2;
        check_eq("conf_count", 64'(conflict_cnt), 64'd10);
        force dut.conflict_cnt = 32'hFFFF_FFFF;
        #1; release dut.conflict_cnt;
        for (int i = 1; i < 3; i++) launch(i, TAG_W'(i + 1), $urandom, 100);
        repeat (3) @(posedge CLK); #2;
        check_eq("conf_saturate", 64'(conflict_cnt), 64'hFFFF_FFFF);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        repeat (3) @(posedge CLK); #2;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among N completing functional units / reservation stations in the OOO-OTTER.
- Grants one tag-value pair per cycle, round-robin, and drives the registered broadcast consumed by the map table, reservation stations and register-file writeback.
- Idle bus carries the invalid tag, so map-table tag comparators never match.

Parameters:
- N_REQ, 4, number of requesters (ALU, LOAD, BRANCH, MUL); 2..8
- TAG_W, 3, width of RS tag field
- DATA_W, 32, width of broadcast data
- INVALID_TAG, 0, tag value driven while the bus is idle; no requester uses it

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  requester i holds a result
- req_tag  in  N_REQ*TAG_W  tag of requester i, slice i
- req_data  in  N_REQ*DATA_W  data of requester i, slice i
- req_ready  out  N_REQ  requester i's result is accepted this cycle
- cdb_hold  in  1  downstream cannot take a broadcast; freeze bus
- cdb_flush  in  1  squash the current broadcast (mispredict recovery)
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  DATA_W  broadcast data

Behaviour:
- Reset (async, any time): cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0, rr_ptr=0.
- req_ready is combinational and never asserted during reset.
- Grant (combinational):
  - The winner is the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo N_REQ.
  - req_ready = one-hot of the winner, gated by ~cdb_hold & ~cdb_flush; all zero if no valid requester.
- Transfer: happens when req_valid[i] & req_ready[i].
  - Next rising edge: cdb_valid=1, cdb_tag/cdb_data = winner's slices. Latency is 1 cycle.
  - Each bus beat lasts exactly one cycle unless held.
- rr_ptr: on transfer, rr_ptr = (winner+1) mod N_REQ. Otherwise it is unchanged.
- No transfer and no hold: next edge cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0.
- cdb_hold=1, cdb_flush=0: output register keeps its value, no grant, rr_ptr unchanged.
- cdb_flush=1: next edge the bus goes idle (cdb_valid=0, cdb_tag=INVALID_TAG), no grant. Flush overrides hold.
- Requester protocol:
  - Once req_valid[i] rises, tag and data stay stable and valid stays high until the ready cycle.
  - A requester may reassert in the cycle after its transfer.
- Fairness: a continuously requesting unit is granted within N_REQ transfers.
- Tag == INVALID_TAG on a valid request: accepted and broadcast unchanged. The bench flags it as a protocol error.
- Simultaneous requests from all units: exactly one grant per non-held cycle; the others wait with signals stable.

Optional Feature:
- Macro CDB_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt [31:0], reset to 0.
  - Increments on each rising edge where a transfer occurs and at least 2 req_valid bits are set.
  - Saturates at 32'hFFFF_FFFF.
  - cdb_flush does not clear it; only RST does.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-broadcast: RST pulsed while cdb_valid=1, tag=3 -> immediately cdb_valid=0, cdb_tag=0, cdb_data=0; the first grant after release goes to requester 0.
- Single request: req_valid=4'b0010, tag=2, data=32'hDEAD_BEEF -> req_ready=4'b0010 the same cycle; next cycle cdb_valid=1, tag=2, data=DEADBEEF; the cycle after, idle with tag 0.
- All four valid continuously with tags 1..4 -> broadcasts on consecutive cycles in tag order 1,2,3,4,1; each req_ready is a one-hot pulse.
- Hold: cdb_hold=1 for 3 cycles while tag 5 is on the bus and requester 2 is pending -> the bus repeats tag 5 for 3 cycles, req_ready=0; requester 2 is broadcast on the cycle after hold drops.
- Flush during hold: cdb_hold=1 and cdb_flush=1 with tag 6 on the bus -> next cycle cdb_valid=0, tag=0; rr_ptr unchanged.
- CDB_PERF_CNT_EN: 10 cycles with 3 valid requesters, then 5 cycles with 1 -> conflict_cnt=10; forced count 32'hFFFF_FFFF stays saturated.
